// File: rtl/framebuffer_loader_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer constants and types. The VGA read path imports the
// same package, so the frame geometry is defined in exactly one place.
//   FB_W / FB_H     : frame stride and height in pixels
//   AW / DW         : RAM address and pixel data widths
//   fb_addr_t       : RAM address type
//   pixel_t         : one grayscale pixel
//   dim_t           : image width/height as carried on the start interface
//   fb_load_state_t : loader FSM states
// ---------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_W = 640;
   localparam int FB_H = 480;
   localparam int AW   = 19;
   localparam int DW   = 8;

   typedef logic [AW-1:0] fb_addr_t;
   typedef logic [DW-1:0] pixel_t;
   typedef logic [9:0]    dim_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      DONE
   } fb_load_state_t;

endpackage

// File: rtl/framebuffer_loader_if.sv
// ---------------------------------------------------------------------------
// framebuffer_loader_if
// Valid/ready pixel stream feeding the frame-buffer loader.
//   s_valid : upstream has a pixel this cycle
//   s_data  : pixel value
//   s_ready : loader takes the pixel this cycle
// Modports: master = upstream producer, slave = loader.
// ---------------------------------------------------------------------------
interface framebuffer_loader_if;
   import fb_pkg::*;

   logic   s_valid;
   pixel_t s_data;
   logic   s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/framebuffer_loader_addr_gen.sv
// ---------------------------------------------------------------------------
// fb_addr_gen
// Raster-order address generator for an image placed top-left in a
// fixed-stride frame. Keeps x, y and the start address of the current row.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   clear       : restart at pixel (0,0)
//   step        : advance to the next pixel
//   w, h        : image dimensions (must be non-zero)
//   last_pixel  : current position is the final pixel of the image
//   addr        : RAM address of the current position
// ---------------------------------------------------------------------------
module fb_addr_gen
   import fb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     clear,
   input  logic     step,
   input  dim_t     w,
   input  dim_t     h,
   output logic     last_pixel,
   output fb_addr_t addr
);

   dim_t     x;
   dim_t     y;
   fb_addr_t line_base;
   logic     end_of_row;

   // Row start is kept as a running sum of the stride, so the address is a
   // single add of x and no y*FB_W multiplier is needed.
   assign end_of_row = (x == w - 10'd1);
   assign last_pixel = end_of_row && (y == h - 10'd1);
   assign addr       = line_base + fb_addr_t'(x);

   // Counter update: wrap x at the end of each row and move to the next row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         line_base <= '0;
      end else if (clear) begin
         x         <= '0;
         y         <= '0;
         line_base <= '0;
      end else if (step) begin
         if (end_of_row) begin
            x         <= '0;
            y         <= y + 10'd1;
            line_base <= line_base + fb_addr_t'(FB_W);
         end else begin
            x <= x + 10'd1;
         end
      end
   end

endmodule

// File: rtl/framebuffer_loader.sv
// ---------------------------------------------------------------------------
// framebuffer_loader
// Streams an 8-bit grayscale image into port B of the shared frame RAM,
// placing it at the top-left of a FB_W-stride frame, and reports completion.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   start           : one-cycle pulse to begin a frame
//   img_w, img_h    : image size, sampled when start is accepted
//   s_if (slave)    : pixel stream (s_valid, s_data, s_ready)
//   wr_addr/data/en : RAM port B write, one cycle after pixel acceptance
//   busy            : loading in progress
//   done            : one-cycle pulse after the last pixel write
//   cfg_err         : one-cycle pulse when start carried an illegal size
//   chk             : 16-bit modular sum of written pixels
//                     (only when FRAMEBUFFER_CHECKSUM_EN is defined)
// ---------------------------------------------------------------------------
module framebuffer_loader
   import fb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     start,
   input  dim_t     img_w,
   input  dim_t     img_h,
   framebuffer_loader_if.slave s_if,
   output fb_addr_t wr_addr,
   output pixel_t   wr_data,
   output logic     wr_en,
   output logic     busy,
   output logic     done,
   output logic     cfg_err
`ifdef FRAMEBUFFER_CHECKSUM_EN
   ,
   output logic [15:0] chk
`endif
);

   localparam dim_t MAX_W = dim_t'(FB_W);
   localparam dim_t MAX_H = dim_t'(FB_H);

   fb_load_state_t state;
   fb_load_state_t next_state;

   dim_t     w_q;
   dim_t     h_q;
   logic     cfg_bad;
   logic     accept_start;
   logic     accept_px;
   logic     last_pixel;
   fb_addr_t pix_addr;

   assign cfg_bad      = (img_w == '0) || (img_h == '0) ||
                         (img_w > MAX_W) || (img_h > MAX_H);
   assign accept_start = (state == IDLE) && start && !cfg_bad;
   assign accept_px    = s_if.s_valid && s_if.s_ready;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

   fb_addr_gen u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (accept_start),
      .step       (accept_px),
      .w          (w_q),
      .h          (h_q),
      .last_pixel (last_pixel),
      .addr       (pix_addr)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and stream ready. Ready comes straight from the state, so it
   // drops on the same edge that takes the final pixel and moves to FLUSH.
   always_comb begin
      next_state    = state;
      s_if.s_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (accept_start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            s_if.s_ready = 1'b1;
            if (accept_px && last_pixel) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            next_state = DONE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Image size capture and the illegal-size error pulse. A start seen
   // outside IDLE is ignored entirely, including for error reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q     <= '0;
         h_q     <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= (state == IDLE) && start && cfg_bad;
         if (accept_start) begin
            w_q <= img_w;
            h_q <= img_h;
         end
      end
   end

   // Registered RAM write: the accepted pixel and its address appear on
   // port B one cycle later. The final write lands during FLUSH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= accept_px;
         if (accept_px) begin
            wr_addr <= pix_addr;
            wr_data <= s_if.s_data;
         end
      end
   end

`ifdef FRAMEBUFFER_CHECKSUM_EN
   // Running sum of what actually reaches the RAM; the last write is added
   // at the end of FLUSH, so the value is settled while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk <= '0;
      end else if (accept_start) begin
         chk <= '0;
      end else if (wr_en) begin
         chk <= chk + 16'(wr_data);
      end
   end
`endif

endmodule

// File: tb/tb_framebuffer_loader.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_loader
// Self-checking bench for framebuffer_loader. Expected RAM writes are queued
// as pixels are driven and compared as the DUT writes them; a table of frame
// configurations drives the main loop, with hand sequences for reset
// mid-frame and the optional checksum (FRAMEBUFFER_CHECKSUM_EN).
// ---------------------------------------------------------------------------
module tb_framebuffer_loader;
   import fb_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   logic     start = 1'b0;
   dim_t     img_w = '0;
   dim_t     img_h = '0;
   fb_addr_t wr_addr;
   pixel_t   wr_data;
   logic     wr_en;
   logic     busy;
   logic     done;
   logic     cfg_err;
`ifdef FRAMEBUFFER_CHECKSUM_EN
   logic [15:0] chk;
`endif

   framebuffer_loader_if fb_if ();

   framebuffer_loader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .img_w   (img_w),
      .img_h   (img_h),
      .s_if    (fb_if),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .busy    (busy),
      .done    (done),
      .cfg_err (cfg_err)
`ifdef FRAMEBUFFER_CHECKSUM_EN
      ,
      .chk     (chk)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      fb_addr_t addr;
      pixel_t   data;
   } wr_rec_t;

   typedef struct {
      int     w;
      int     h;
      bit     gaps;
      bit     mid_start;
      bit     exp_err;
      pixel_t base;
      string  tag;
   } frame_vec_t;

   wr_rec_t     exp_q[$];
   frame_vec_t  vecs[10];
   int          checks = 0;
   int          errors = 0;
   int          wr_count = 0;
   int          done_count = 0;
   int          err_count = 0;
   int          busy_seen = 0;
   logic [15:0] model_sum = '0;
   logic [15:0] chk_at_done = '0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Write monitor: every RAM write must match the oldest queued pixel.
   always @(negedge clk) begin
      wr_rec_t r;
      if (rst_n) begin
         if (busy) busy_seen++;
         if (cfg_err) err_count++;
         if (done) begin
            done_count++;
`ifdef FRAMEBUFFER_CHECKSUM_EN
            chk_at_done = chk;
`endif
         end
         if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               check_output("unexpected_wr_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
               r = exp_q.pop_front();
               check_output("wr_addr", 32'(wr_addr), 32'(r.addr));
               check_output("wr_data", 32'(wr_data), 32'(r.data));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic reset_counters();
      wr_count   = 0;
      done_count = 0;
      err_count  = 0;
      busy_seen  = 0;
      model_sum  = '0;
   endtask

   task automatic pulse_start(input int w, input int h);
      @(posedge clk); #1;
      start = 1'b1;
      img_w = dim_t'(w);
      img_h = dim_t'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer one pixel, optionally after idle cycles and with a stray start.
   task automatic feed_pixel(input int x, input int y, input pixel_t d,
                             input bit gaps, input bit start_too);
      int guard;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            fb_if.s_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      fb_if.s_valid = 1'b1;
      fb_if.s_data  = d;
      if (start_too) begin
         start = 1'b1;
         img_w = 10'd1;
         img_h = 10'd1;
      end
      guard = 0;
      while (!fb_if.s_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!fb_if.s_ready) begin
         check_output("s_ready_timeout", 32'(fb_if.s_ready), 32'd1);
      end
      exp_q.push_back('{addr: fb_addr_t'(y * FB_W + x), data: d});
      model_sum = model_sum + 16'(d);
      @(posedge clk); #1;
      fb_if.s_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_frame(input int w, input int h, input string tag);
      repeat (6) @(posedge clk);
      #1;
      check_output({tag, "_done_count"}, 32'(done_count), 32'd1);
      check_output({tag, "_wr_count"}, 32'(wr_count), 32'(w * h));
      check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
      check_output({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
      check_output({tag, "_cfg_err"}, 32'(err_count), 32'd0);
   endtask

   task automatic apply_stimulus(input frame_vec_t v);
      int idx;
      reset_counters();
      pulse_start(v.w, v.h);
      if (v.exp_err) begin
         repeat (4) @(posedge clk);
         #1;
         check_output({v.tag, "_cfg_err"}, 32'(err_count), 32'd1);
         check_output({v.tag, "_busy_seen"}, 32'(busy_seen), 32'd0);
         check_output({v.tag, "_wr_count"}, 32'(wr_count), 32'd0);
         check_output({v.tag, "_done_count"}, 32'(done_count), 32'd0);
      end else begin
         check_output({v.tag, "_busy_start"}, 32'(busy), 32'd1);
         idx = 0;
         for (int y = 0; y < v.h; y++) begin
            for (int x = 0; x < v.w; x++) begin
               feed_pixel(x, y, v.base + pixel_t'(idx), v.gaps,
                          v.mid_start && (idx == (v.w * v.h) / 2));
               idx++;
            end
         end
         finish_frame(v.w, v.h, v.tag);
      end
   endtask

   initial begin
      vecs[0] = '{w: 4,   h: 2,   gaps: 0, mid_start: 0, exp_err: 0, base: 8'h10, tag: "w4h2"};
      vecs[1] = '{w: 0,   h: 5,   gaps: 0, mid_start: 0, exp_err: 1, base: 8'h00, tag: "w0h5"};
      vecs[2] = '{w: 641, h: 1,   gaps: 0, mid_start: 0, exp_err: 1, base: 8'h00, tag: "w641h1"};
      vecs[3] = '{w: 5,   h: 0,   gaps: 0, mid_start: 0, exp_err: 1, base: 8'h00, tag: "w5h0"};
      vecs[4] = '{w: 1,   h: 481, gaps: 0, mid_start: 0, exp_err: 1, base: 8'h00, tag: "w1h481"};
      vecs[5] = '{w: 3,   h: 3,   gaps: 1, mid_start: 1, exp_err: 0, base: 8'hA0, tag: "w3h3_gaps"};
      vecs[6] = '{w: 640, h: 2,   gaps: 0, mid_start: 0, exp_err: 0, base: 8'h00, tag: "w640h2"};
      vecs[7] = '{w: 1,   h: 480, gaps: 0, mid_start: 0, exp_err: 0, base: 8'h55, tag: "w1h480"};
      vecs[8] = '{w: 1,   h: 1,   gaps: 1, mid_start: 0, exp_err: 0, base: 8'hFE, tag: "w1h1"};
      vecs[9] = '{w: 7,   h: 4,   gaps: 1, mid_start: 1, exp_err: 0, base: 8'h30, tag: "w7h4_gaps"};

      fb_if.s_valid = 1'b0;
      fb_if.s_data  = '0;

      // Reset state.
      #1;
      check_output("rst_wr_en", 32'(wr_en), 32'd0);
      check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_output("rst_wr_data", 32'(wr_data), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_cfg_err", 32'(cfg_err), 32'd0);
      check_output("rst_s_ready", 32'(fb_if.s_ready), 32'd0);
      #20;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i]);
      end

      // Largest legal frame is accepted; reset it after 5 pixels.
      reset_counters();
      pulse_start(640, 480);
      check_output("max_busy", 32'(busy), 32'd1);
      for (int x = 0; x < 5; x++) begin
         feed_pixel(x, 0, pixel_t'(8'hC0 + x), 1'b0, 1'b0);
      end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_output("midrst_wr_en", 32'(wr_en), 32'd0);
      check_output("midrst_wr_addr", 32'(wr_addr), 32'd0);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_s_ready", 32'(fb_if.s_ready), 32'd0);
      check_output("midrst_cfg_err", 32'(err_count), 32'd0);
      check_output("midrst_wr_count", 32'(wr_count), 32'd5);
      check_output("midrst_queue_left", 32'(exp_q.size()), 32'd0);
      #17;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("midrst_no_done", 32'(done_count), 32'd0);
      apply_stimulus('{w: 2, h: 1, gaps: 0, mid_start: 0, exp_err: 0, base: 8'h21, tag: "after_rst"});

`ifdef FRAMEBUFFER_CHECKSUM_EN
      reset_counters();
      pulse_start(2, 2);
      feed_pixel(0, 0, 8'hFF, 1'b0, 1'b0);
      feed_pixel(1, 0, 8'hFF, 1'b0, 1'b0);
      feed_pixel(0, 1, 8'hFF, 1'b0, 1'b0);
      feed_pixel(1, 1, 8'h03, 1'b0, 1'b0);
      finish_frame(2, 2, "chk");
      check_output("chk_model", 32'(chk_at_done), 32'(model_sum));
      check_output("chk_value", 32'(chk_at_done), 32'h0300);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
